// File: rtl/eva_ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS per accepted AHB single transfer,
// with wait-state insertion, read-data return and two-cycle ERROR on slave error, timeout or illegal transfer.
module eva_ahb2apb_bridge #(
  parameter int HAW     = 32,
  parameter int PAW     = 16,
  parameter int TIMEOUT = 256
) (
  input  logic           hclk,
  input  logic           rst_n,
  input  logic           hsel,
  input  logic [1:0]     htrans,
  input  logic           hwrite,
  input  logic [2:0]     hsize,
  input  logic [HAW-1:0] haddr,
  input  logic [31:0]    hwdata,
  input  logic           hready_in,
  output logic           hready_out,
  output logic [1:0]     hresp,
  output logic [31:0]    hrdata,
  output logic           psel,
  output logic           penable,
  output logic           pwrite,
  output logic [PAW-1:0] paddr,
  output logic [31:0]    pwdata,
  output logic [3:0]     pstrb,
  input  logic           pready,
  input  logic           pslverr,
  input  logic [31:0]    prdata
);

  // state  | meaning
  // IDLE   | no transfer in flight, ready for an address phase
  // SETUP  | APB setup cycle (psel=1, penable=0)
  // ACCESS | APB access cycle, waiting for pready or timeout
  // DONE   | OKAY completion cycle, may accept the next transfer
  // ERR1   | first ERROR cycle, hready_out=0
  // ERR2   | second ERROR cycle, may accept the next transfer
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          can_accept;
  logic          accept;
  logic          legal;
  logic          tmo;
  logic [3:0]    strb_nxt;
  logic          unused_ok;

  assign can_accept = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
  assign accept     = hsel & htrans[1] & hready_in & can_accept;
  assign tmo        = (TIMEOUT != 0) && (cnt == TC);
  assign pwdata     = hwdata;
  assign unused_ok  = ^{htrans[0], haddr[HAW-1:PAW]};

  always_comb begin
    legal    = 1'b0;
    strb_nxt = 4'b0000;
    case (hsize)
      3'd0: begin
        legal    = 1'b1;
        strb_nxt = 4'b0001 << haddr[1:0];
      end
      3'd1: begin
        legal    = ~haddr[0];
        strb_nxt = haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        legal    = (haddr[1:0] == 2'b00);
        strb_nxt = 4'b1111;
      end
      default: begin
        legal    = 1'b0;
        strb_nxt = 4'b0000;
      end
    endcase
  end

  always_comb begin
    state_nxt  = state;
    hready_out = 1'b1;
    hresp      = 2'b00;
    case (state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (state == S_ERR2) hresp = 2'b01;
        if (accept) state_nxt = legal ? S_SETUP : S_ERR1;
        else        state_nxt = S_IDLE;
      end
      S_SETUP: begin
        hready_out = 1'b0;
        state_nxt  = S_ACCESS;
      end
      S_ACCESS: begin
        hready_out = 1'b0;
        if (pready)   state_nxt = pslverr ? S_ERR1 : S_DONE;
        else if (tmo) state_nxt = S_ERR1;
      end
      S_ERR1: begin
        hready_out = 1'b0;
        hresp      = 2'b01;
        state_nxt  = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pstrb   <= 4'b0000;
      hrdata  <= 32'h0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      psel    <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
      penable <= (state_nxt == S_ACCESS);
      cnt     <= ((state == S_ACCESS) && (state_nxt == S_ACCESS)) ? cnt + 1'b1 : '0;
      // APB address/control only reload on a legal accept, so they hold through ACCESS
      if (accept && legal) begin
        paddr  <= haddr[PAW-1:0];
        pwrite <= hwrite;
        pstrb  <= hwrite ? strb_nxt : 4'b0000;
      end
      if ((state == S_ACCESS) && pready && !pslverr && !pwrite) hrdata <= prdata;
    end
  end

endmodule

// File: tb/tb_eva_ahb2apb_bridge.sv
// Scoreboard bench for eva_ahb2apb_bridge: randomized AHB transfers against a transfer-level model,
// plus a TIMEOUT=0 instance for the long-stall case.
module tb_eva_ahb2apb_bridge;
  localparam int TO = 4;

  typedef struct {
    bit          legal;
    bit          err;
    bit          wr;
    logic [15:0] paddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          acc;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          w;
    bit          err;
    logic [31:0] prd;
  } apb_t;

  logic        hclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0, hready_in, hready_out;
  logic [1:0]  htrans = 2'b00, hresp;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] haddr = 32'h0, hwdata = 32'h0, hrdata, pwdata, prdata = 32'h0;
  logic        psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;
  logic [15:0] paddr;
  logic [3:0]  pstrb;

  logic        hsel_z = 1'b0, hwrite_z = 1'b0, hready_out_z, pready_z = 1'b0;
  logic [1:0]  htrans_z = 2'b00, hresp_z;
  logic [2:0]  hsize_z = 3'd2;
  logic [31:0] haddr_z = 32'h0, hwdata_z = 32'h0, hrdata_z, pwdata_z, prdata_z = 32'h0;
  logic        psel_z, penable_z, pwrite_z;
  logic [15:0] paddr_z;
  logic [3:0]  pstrb_z;

  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  apb_t apb_q[$];
  logic [31:0] model_rd = 32'h0;

  assign hready_in = hready_out;
  always #5 hclk = ~hclk;

  eva_ahb2apb_bridge #(.HAW(32), .PAW(16), .TIMEOUT(TO)) dut (
    .hclk(hclk), .rst_n(rst_n), .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .haddr(haddr), .hwdata(hwdata), .hready_in(hready_in), .hready_out(hready_out), .hresp(hresp),
    .hrdata(hrdata), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  eva_ahb2apb_bridge #(.HAW(32), .PAW(16), .TIMEOUT(0)) dut_z (
    .hclk(hclk), .rst_n(rst_n), .hsel(hsel_z), .htrans(htrans_z), .hwrite(hwrite_z), .hsize(hsize_z),
    .haddr(haddr_z), .hwdata(hwdata_z), .hready_in(hready_out_z), .hready_out(hready_out_z),
    .hresp(hresp_z), .hrdata(hrdata_z), .psel(psel_z), .penable(penable_z), .pwrite(pwrite_z),
    .paddr(paddr_z), .pwdata(pwdata_z), .pstrb(pstrb_z), .pready(pready_z), .pslverr(1'b0),
    .prdata(prdata_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // APB slave: each popped entry says how many ACCESS cycles to stall and whether to flag an error
  apb_t cur;
  bit   s_active = 0;
  int   s_k = 0;
  always @(negedge hclk) begin
    if (!rst_n) begin
      s_active = 0;
      pready   = 1'b0;
      pslverr  = 1'b0;
    end else if (psel && !penable) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      if (apb_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_setup: got psel expected none at %0t", $time);
        s_active = 0;
      end else begin
        cur = apb_q.pop_front();
        s_active = 1;
        s_k = 0;
      end
    end else if (psel && penable && s_active) begin
      pready  = (s_k == cur.w);
      pslverr = cur.err && (s_k == cur.w);
      prdata  = cur.prd;
      s_k++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // Monitor: measures each AHB data phase and checks it against the queued expectation
  bit          m_busy = 0, m_first_setup, m_unstable, m_wr, m_last_psel;
  int          m_waits, m_acc, m_psel_cnt;
  logic [1:0]  m_last_hresp;
  logic [15:0] m_paddr;
  logic [3:0]  m_strb;
  logic [31:0] m_wd;

  task automatic complete();
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("hresp", {30'h0, hresp}, e.err ? 32'd1 : 32'd0);
      chk("wait_states", m_waits, e.waits);
      chk("access_cycles", m_acc, e.acc);
      chk("psel_cycles", m_psel_cnt, e.legal ? e.acc + 1 : 0);
      chk("hrdata", hrdata, e.rdata);
      if (e.legal) begin
        chk("setup_first", {31'h0, m_first_setup}, 32'd1);
        chk("paddr", {16'h0, m_paddr}, {16'h0, e.paddr});
        chk("pstrb", {28'h0, m_strb}, {28'h0, e.strb});
        chk("pwrite", {31'h0, m_wr}, {31'h0, e.wr});
        chk("apb_stable", {31'h0, m_unstable}, 32'd0);
        if (e.wr) chk("pwdata", m_wd, e.wdata);
      end
      if (e.err) begin
        chk("err1_hresp", {30'h0, m_last_hresp}, 32'd1);
        chk("err1_psel", {31'h0, m_last_psel}, 32'd0);
      end
    end
  endtask

  always @(negedge hclk) begin
    if (!rst_n) m_busy = 0;
    else begin
      if (m_busy) begin
        if (!hready_out) begin
          m_waits++;
          if (m_waits == 1) m_first_setup = psel && !penable;
          if (psel) m_psel_cnt++;
          if (psel && penable) begin
            m_acc++;
            if (m_acc == 1) begin
              m_paddr = paddr; m_strb = pstrb; m_wr = pwrite; m_wd = pwdata;
            end else if (paddr !== m_paddr || pstrb !== m_strb || pwrite !== m_wr || pwdata !== m_wd)
              m_unstable = 1;
          end
          m_last_hresp = hresp;
          m_last_psel  = psel;
        end else begin
          complete();
          m_busy = 0;
        end
      end
      if (hsel && htrans[1] && hready_out) begin
        m_busy = 1; m_waits = 0; m_acc = 0; m_psel_cnt = 0;
        m_first_setup = 0; m_unstable = 0; m_last_psel = 0; m_last_hresp = 2'b00;
      end
    end
  end

  // Issue one AHB transfer; returns one cycle after its address phase is accepted
  task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input bit wr,
                      input logic [31:0] wd, input int w, input bit err, input logic [31:0] prd);
    int n, nb;
    bit timed, serr;
    exp_t e;
    apb_t a;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hsize = size; hwrite = wr;
    n = 0;
    while (!hready_out && n < 200) begin
      @(posedge hclk); #1; n++;
    end
    if (n >= 200) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: got hready_out=0 expected 1 at %0t", $time);
    end
    nb       = (size <= 3'd2) ? (1 << size) : 1;
    e.legal  = (size <= 3'd2) && ((addr % nb) == 0);
    timed    = e.legal && (w >= TO);
    serr     = e.legal && !timed && err;
    e.err    = !e.legal || timed || serr;
    e.wr     = wr;
    e.paddr  = addr[15:0];
    e.strb   = wr ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'h0;
    e.wdata  = wd;
    e.acc    = !e.legal ? 0 : (timed ? TO : w + 1);
    e.waits  = !e.legal ? 1 : 1 + e.acc + (e.err ? 1 : 0);
    if (e.legal && !e.err && !wr) model_rd = prd;
    e.rdata  = model_rd;
    exp_q.push_back(e);
    if (e.legal) begin
      a.w = w; a.err = err; a.prd = prd;
      apb_q.push_back(a);
    end
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd; haddr = $urandom;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      hsel = 1'($urandom_range(0, 1));
      htrans = 2'($urandom_range(0, 1));
      @(posedge hclk); #1;
    end
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < 200) begin
      @(posedge hclk); #1; n++;
    end
    if (n >= 200) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sz;
    int w;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hready_out", {31'h0, hready_out}, 32'd1);
    chk("rst_hresp", {30'h0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_psel", {31'h0, psel}, 32'd0);
    chk("rst_penable", {31'h0, penable}, 32'd0);
    chk("rst_paddr", {16'h0, paddr}, 32'h0);
    chk("rst_pstrb", {28'h0, pstrb}, 32'h0);
    chk("rst_pwrite", {31'h0, pwrite}, 32'd0);
    rst_n = 1'b1;
    @(posedge hclk); #1;

    xfer(32'h0000_1234, 3'd2, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    gap(3);
    xfer(32'h0000_2000, 3'd2, 0, 32'h0, 5, 0, 32'hA5A5_0001);
    xfer(32'h0000_3003, 3'd0, 1, 32'h1122_3344, 0, 0, 32'h0);
    xfer(32'h0000_3002, 3'd1, 1, 32'h5566_7788, 1, 0, 32'h0);
    xfer(32'h0000_3002, 3'd2, 1, 32'h99AA_BBCC, 0, 0, 32'h0);
    xfer(32'h0000_4000, 3'd2, 1, 32'h0000_0042, 0, 1, 32'h0);
    xfer(32'h0000_4004, 3'd2, 0, 32'h0, 0, 0, 32'h1111_2222);
    xfer(32'h0000_5000, 3'd2, 0, 32'h0, 9, 0, 32'h3333_4444);
    xfer(32'h0000_6000, 3'd2, 0, 32'h0, 0, 0, 32'h5555_6666);
    xfer(32'h0000_6004, 3'd2, 0, 32'h0, 0, 0, 32'h7777_8888);
    drain();

    for (int i = 0; i < 80; i++) begin
      sz = 3'($urandom_range(0, 3));
      w  = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
      xfer($urandom, sz, 1'($urandom_range(0, 1)), $urandom, w,
           ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 4));
    end
    drain();

    xfer(32'h0000_0040, 3'd2, 0, 32'h0, 20, 0, 32'hCAFE_0001);
    @(posedge hclk); #1;
    chk("pre_rst_penable", {31'h0, penable}, 32'd1);
    rst_n = 1'b0;
    @(posedge hclk); #1;
    chk("arst_psel", {31'h0, psel}, 32'd0);
    chk("arst_penable", {31'h0, penable}, 32'd0);
    chk("arst_hready_out", {31'h0, hready_out}, 32'd1);
    chk("arst_hresp", {30'h0, hresp}, 32'd0);
    chk("arst_hrdata", hrdata, 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    apb_q.delete();
    model_rd = 32'h0;
    xfer(32'h0000_0100, 3'd2, 0, 32'h0, 1, 0, 32'h0BAD_F00D);
    xfer(32'h0000_0104, 3'd2, 0, 32'h0, 0, 0, 32'h1234_5678);
    drain();

    hsel_z = 1'b1; htrans_z = 2'b10; haddr_z = 32'h0000_0080; hsize_z = 3'd2; hwrite_z = 1'b0;
    chk("z_ready_idle", {31'h0, hready_out_z}, 32'd1);
    @(posedge hclk); #1;
    hsel_z = 1'b0; htrans_z = 2'b00;
    chk("z_setup", {30'h0, psel_z, penable_z}, 32'd2);
    repeat (1000) @(posedge hclk);
    #1;
    chk("z_stall_access", {29'h0, psel_z, penable_z, hready_out_z}, 32'd6);
    prdata_z = 32'hFEED_0BEE;
    pready_z = 1'b1;
    @(posedge hclk); #1;
    pready_z = 1'b0;
    chk("z_done_ready", {31'h0, hready_out_z}, 32'd1);
    chk("z_done_hresp", {30'h0, hresp_z}, 32'd0);
    chk("z_done_hrdata", hrdata_z, 32'hFEED_0BEE);
    chk("z_done_psel", {31'h0, psel_z}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
